// File: rtl/spi_block_crc_check.sv
// spi_block_crc_check
//   Receive-side framing and CRC check for SD-style SPI data blocks.
//   Hunts for the start token, forwards BLOCK_LEN payload bytes downstream
//   and into an external byte-wise CRC16 engine, captures the engine result,
//   compares it with the two trailing CRC bytes and reports the outcome.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   arm                   start a block receive (honoured only in IDLE)
//   abort                 return to IDLE at once, no done pulse
//   rx_data, rx_valid     byte stream from the SPI receiver
//   out_data, out_valid   forwarded payload bytes (registered)
//   crc_clr, crc_start,   control/data towards the CRC engine
//   crc_data
//   crc_in, crc_rdy       CRC engine result and its strobe
//   busy                  high in every state except IDLE
//   done                  one-cycle completion pulse
//   crc_ok, crc_err,      status flags, exactly one set after each done;
//   tok_err, timeout      held until the next arm
//   err_token             offending byte when tok_err=1
module spi_block_crc_check #(
  parameter int         BLOCK_LEN     = 512,
  parameter logic [7:0] START_TOKEN   = 8'hFE,
  parameter int         TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        abort,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        crc_clr,
  output logic        crc_start,
  output logic [7:0]  crc_data,
  input  logic [15:0] crc_in,
  input  logic        crc_rdy,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        tok_err,
  output logic        timeout,
  output logic [7:0]  err_token
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam int FF_W  = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_LEN - 1);
  localparam logic [FF_W-1:0]  FF_LAST   = FF_W'(TOKEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TOKEN,
    DATA,
    CRC_HI,
    CRC_LO,
    CHECK
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [FF_W-1:0]   ff_cnt;
  logic [15:0]       crc_cap;
  logic [15:0]       rx_crc;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      ff_cnt    <= '0;
      crc_cap   <= '0;
      rx_crc    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      crc_clr   <= 1'b0;
      crc_start <= 1'b0;
      crc_data  <= '0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      tok_err   <= 1'b0;
      timeout   <= 1'b0;
      err_token <= '0;
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      crc_clr   <= 1'b0;
      crc_start <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;

      // The engine result is captured whenever offered; with back-to-back
      // bytes the last payload CRC lands here by the CHECK cycle.
      if (crc_rdy) begin
        crc_cap <= crc_in;
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm) begin
              crc_clr <= 1'b1;
              crc_ok  <= 1'b0;
              crc_err <= 1'b0;
              tok_err <= 1'b0;
              timeout <= 1'b0;
              ff_cnt  <= '0;
              state   <= WAIT_TOKEN;
            end
          end

          WAIT_TOKEN: begin
            if (rx_valid) begin
              if (rx_data == START_TOKEN) begin
                byte_cnt <= '0;
                state    <= DATA;
              end else if (rx_data == 8'hFF) begin
                ff_cnt <= ff_cnt + FF_W'(1);
                if (ff_cnt == FF_LAST) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= IDLE;
                end
              end else begin
                err_token <= rx_data;
                tok_err   <= 1'b1;
                done      <= 1'b1;
                state     <= IDLE;
              end
            end
          end

          DATA: begin
            if (rx_valid) begin
              crc_start <= 1'b1;
              crc_data  <= rx_data;
              out_valid <= 1'b1;
              out_data  <= rx_data;
              byte_cnt  <= byte_cnt + CNT_W'(1);
              if (byte_cnt == LAST_BYTE) begin
                state <= CRC_HI;
              end
            end
          end

          CRC_HI: begin
            if (rx_valid) begin
              rx_crc[15:8] <= rx_data;
              state        <= CRC_LO;
            end
          end

          CRC_LO: begin
            if (rx_valid) begin
              rx_crc[7:0] <= rx_data;
              state       <= CHECK;
            end
          end

          CHECK: begin
            if (crc_cap == rx_crc) begin
              crc_ok <= 1'b1;
            end else begin
              crc_err <= 1'b1;
            end
            done  <= 1'b1;
            state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_block_crc_check.sv
// Testbench for spi_block_crc_check: two instances (512-byte blocks with a
// short token timeout, and 9-byte blocks), each with a behavioural CRC16
// engine. Table vectors, hand-written abort/reset sequences and randomized
// frames checked against a frame-level reference model.
module tb_spi_block_crc_check;

  localparam int BL0 = 512;
  localparam int TO0 = 4;
  localparam int BL1 = 9;
  localparam int TO1 = 1024;

  localparam logic [3:0] F_OK  = 4'b1000;
  localparam logic [3:0] F_ERR = 4'b0100;
  localparam logic [3:0] F_TOK = 4'b0010;
  localparam logic [3:0] F_TMO = 4'b0001;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm[2], abort[2], rx_valid[2];
  logic [7:0]  rx_data[2];
  logic [7:0]  out_data[2], crc_data[2], err_token[2];
  logic        out_valid[2], crc_clr[2], crc_start[2], busy[2], done[2];
  logic        crc_ok[2], crc_err[2], tok_err[2], timeout[2];
  logic [15:0] crc_in[2];
  logic        crc_rdy[2];
  logic [15:0] eng[2];

  always #5 clk = ~clk;

  spi_block_crc_check #(.BLOCK_LEN(BL0), .START_TOKEN(8'hFE), .TOKEN_TIMEOUT(TO0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm[0]), .abort(abort[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]),
    .crc_clr(crc_clr[0]), .crc_start(crc_start[0]), .crc_data(crc_data[0]),
    .crc_in(crc_in[0]), .crc_rdy(crc_rdy[0]),
    .busy(busy[0]), .done(done[0]), .crc_ok(crc_ok[0]), .crc_err(crc_err[0]),
    .tok_err(tok_err[0]), .timeout(timeout[0]), .err_token(err_token[0])
  );

  spi_block_crc_check #(.BLOCK_LEN(BL1), .START_TOKEN(8'hFE), .TOKEN_TIMEOUT(TO1)) dut1 (
    .clk(clk), .rst(rst), .arm(arm[1]), .abort(abort[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]),
    .crc_clr(crc_clr[1]), .crc_start(crc_start[1]), .crc_data(crc_data[1]),
    .crc_in(crc_in[1]), .crc_rdy(crc_rdy[1]),
    .busy(busy[1]), .done(done[1]), .crc_ok(crc_ok[1]), .crc_err(crc_err[1]),
    .tok_err(tok_err[1]), .timeout(timeout[1]), .err_token(err_token[1])
  );

  // CRC16-CCITT, polynomial 0x1021, MSB first, one byte at a time.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_of(input bq_t q);
    logic [15:0] c;
    c = 16'h0000;
    foreach (q[i]) c = crc_byte(c, q[i]);
    return c;
  endfunction

  // Behavioural CRC engine: result one cycle after crc_start; crc_in is
  // garbage whenever crc_rdy is low.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        eng[i]     <= 16'h0000;
        crc_rdy[i] <= 1'b0;
        crc_in[i]  <= 16'h0000;
      end else begin
        crc_rdy[i] <= crc_start[i];
        if (crc_start[i]) begin
          eng[i]    <= crc_byte(eng[i], crc_data[i]);
          crc_in[i] <= crc_byte(eng[i], crc_data[i]);
        end else begin
          crc_in[i] <= 16'($urandom);
          if (crc_clr[i]) eng[i] <= 16'h0000;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the selected instance, sampled on the falling edge.
  int         sel = 0;
  bq_t        out_q, cs_q;
  int         clr_cnt, clr_cyc, first_start_cyc, overlap_cnt;
  int         done_cnt, done_cyc;
  logic [3:0] done_flags;
  logic [7:0] done_err;

  initial forever begin
    @(negedge clk);
    if (out_valid[sel]) out_q.push_back(out_data[sel]);
    if (crc_start[sel]) begin
      cs_q.push_back(crc_data[sel]);
      if (first_start_cyc < 0) first_start_cyc = cyc;
    end
    if (crc_clr[sel]) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
    if (crc_clr[sel] && crc_start[sel]) overlap_cnt++;
    if (done[sel]) begin
      done_cnt++;
      done_cyc   = cyc;
      done_flags = {crc_ok[sel], crc_err[sel], tok_err[sel], timeout[sel]};
      done_err   = err_token[sel];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    out_q.delete();
    cs_q.delete();
    clr_cnt = 0; clr_cyc = -1; first_start_cyc = -1; overlap_cnt = 0;
    done_cnt = 0; done_cyc = -1; done_flags = '0; done_err = '0;
  endtask

  int last_put;

  task automatic put(input logic [7:0] b, input logic a = 1'b0);
    @(negedge clk);
    rx_valid[sel] = 1'b1; rx_data[sel] = b; arm[sel] = a; abort[sel] = 1'b0;
    last_put = cyc;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid[sel] = 1'b0; arm[sel] = 1'b0; abort[sel] = 1'b0;
      #1;
    end
  endtask

  task automatic gap_idle(input int g);
    if (g > 0) idle($urandom_range(g, 0));
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (done_cnt == 0 && k < lim) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic chk_zero_outputs(input int d, input string tag);
    chk({tag, "_strobes_flags"},
        32'({out_valid[d], crc_clr[d], crc_start[d], busy[d], done[d],
             crc_ok[d], crc_err[d], tok_err[d], timeout[d]}), 32'h0);
    chk({tag, "_data_outs"}, 32'({out_data[d], crc_data[d], err_token[d]}), 32'h0);
  endtask

  task automatic run_frame(input int d, input int n_ff, input logic [7:0] tok, input bq_t pay,
                           input logic [15:0] trail, input int gap, input logic rearm,
                           input logic [3:0] exp_flags, input logic [7:0] exp_err,
                           input string tag);
    int bad_out, bad_cs;
    sel = d;
    clear_mon();
    @(negedge clk); arm[sel] = 1'b1; #1;
    @(negedge clk); arm[sel] = 1'b0; #1;
    chk({tag, "_busy_after_arm"}, 32'(busy[d]), 32'd1);
    chk({tag, "_flags_cleared"}, 32'({crc_ok[d], crc_err[d], tok_err[d], timeout[d]}), 32'd0);
    for (int i = 0; i < n_ff; i++) begin
      put(8'hFF);
      if (i != n_ff - 1 || exp_flags != F_TMO) gap_idle(gap);
    end
    if (exp_flags != F_TMO) begin
      put(tok, rearm);
      if (tok == 8'hFE) begin
        foreach (pay[i]) begin
          gap_idle(gap);
          put(pay[i]);
        end
        gap_idle(gap);
        put(trail[15:8]);
        gap_idle(gap);
        put(trail[7:0]);
      end
    end
    idle(1);
    wait_done(20);
    idle(3);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_status"}, 32'(done_flags), 32'(exp_flags));
    chk({tag, "_done_latency"}, 32'(done_cyc - last_put),
        (exp_flags == F_OK || exp_flags == F_ERR) ? 32'd2 : 32'd1);
    if (exp_flags == F_TOK) chk({tag, "_err_token"}, 32'(done_err), 32'(exp_err));
    chk({tag, "_busy_idle"}, 32'(busy[d]), 32'd0);
    chk({tag, "_clr_count"}, 32'(clr_cnt), 32'd1);
    chk({tag, "_clr_start_overlap"}, 32'(overlap_cnt), 32'd0);
    if (exp_flags == F_OK || exp_flags == F_ERR) begin
      chk({tag, "_out_count"}, 32'(out_q.size()), 32'(pay.size()));
      chk({tag, "_crc_start_count"}, 32'(cs_q.size()), 32'(pay.size()));
      bad_out = 0; bad_cs = 0;
      for (int i = 0; i < pay.size(); i++) begin
        if (i >= out_q.size() || out_q[i] !== pay[i]) bad_out++;
        if (i >= cs_q.size() || cs_q[i] !== pay[i]) bad_cs++;
      end
      chk({tag, "_out_bytes_wrong"}, 32'(bad_out), 32'd0);
      chk({tag, "_crc_bytes_wrong"}, 32'(bad_cs), 32'd0);
      chk({tag, "_clr_before_start"}, 32'(first_start_cyc > clr_cyc), 32'd1);
    end else begin
      chk({tag, "_no_payload"}, 32'(out_q.size() + cs_q.size()), 32'd0);
    end
  endtask

  function automatic bq_t make_pay(input int kind, input int d);
    bq_t q;
    if (kind == 0) begin
      for (int i = 0; i < (d == 0 ? BL0 : BL1); i++) q.push_back(8'hFF);
    end else if (kind == 1) begin
      for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    end
    return q;
  endfunction

  typedef struct {
    int         d;
    int         n_ff;
    logic [7:0] tok;
    int         pk;
    logic [15:0] trail;
    int         gap;
    logic       rearm;
    logic [3:0] flags;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[8];

  // Frame-level reference: timeout, bad token, then CRC compare.
  task automatic random_frames(input int n);
    int          d, to, bl, nff;
    logic        bad;
    logic [7:0]  tok;
    logic [15:0] trail;
    logic [3:0]  exp;
    bq_t         pay;
    for (int k = 0; k < n; k++) begin
      d   = (k % 4 == 0) ? 0 : 1;
      to  = (d == 0) ? TO0 : TO1;
      bl  = (d == 0) ? BL0 : BL1;
      nff = $urandom_range((d == 0) ? 5 : 3, 0);
      bad = ($urandom_range(5, 0) == 0);
      tok = bad ? 8'($urandom_range(253, 0)) : 8'hFE;
      pay.delete();
      for (int i = 0; i < bl; i++) pay.push_back(8'($urandom));
      trail = crc_of(pay);
      if ($urandom_range(1, 0) == 1) trail = trail ^ (16'h1 << $urandom_range(15, 0));
      if (nff >= to) begin
        exp = F_TMO;
        nff = to;
      end else if (bad) begin
        exp = F_TOK;
      end else begin
        exp = (crc_of(pay) == trail) ? F_OK : F_ERR;
      end
      run_frame(d, nff, tok, pay, trail, 2, 1'($urandom_range(1, 0)), exp, tok,
                $sformatf("rnd%0d", k));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      arm[i] = 1'b0; abort[i] = 1'b0; rx_valid[i] = 1'b0; rx_data[i] = 8'h00;
    end
    clear_mon();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_zero_outputs(0, "reset_dut0");
    chk_zero_outputs(1, "reset_dut1");
    @(negedge clk); rst = 1'b0; #1;

    tbl[0] = '{0, 3, 8'hFE, 0, 16'h7FA1, 0, 1'b0, F_OK,  8'h00};
    tbl[1] = '{0, 3, 8'hFE, 0, 16'h7FA0, 0, 1'b0, F_ERR, 8'h00};
    tbl[2] = '{1, 0, 8'hFE, 1, 16'h31C3, 3, 1'b0, F_OK,  8'h00};
    tbl[3] = '{0, 4, 8'hFE, 2, 16'h0000, 0, 1'b0, F_TMO, 8'h00};
    tbl[4] = '{0, 1, 8'h05, 2, 16'h0000, 0, 1'b0, F_TOK, 8'h05};
    tbl[5] = '{1, 2, 8'hFE, 1, 16'h31C3, 0, 1'b1, F_OK,  8'h00};
    tbl[6] = '{1, 0, 8'h00, 2, 16'h0000, 0, 1'b0, F_TOK, 8'h00};
    tbl[7] = '{1, 1, 8'hFE, 1, 16'h31C2, 1, 1'b0, F_ERR, 8'h00};

    for (int k = 0; k < 8; k++) begin
      run_frame(tbl[k].d, tbl[k].n_ff, tbl[k].tok, make_pay(tbl[k].pk, tbl[k].d),
                tbl[k].trail, tbl[k].gap, tbl[k].rearm, tbl[k].flags, tbl[k].err,
                $sformatf("vec%0d", k));
    end

    // Abort after 100 payload bytes, with a byte offered in the abort cycle.
    sel = 0;
    clear_mon();
    @(negedge clk); arm[0] = 1'b1; #1;
    @(negedge clk); arm[0] = 1'b0; #1;
    put(8'hFE);
    for (int i = 0; i < 100; i++) put(8'($urandom));
    @(negedge clk); abort[0] = 1'b1; rx_valid[0] = 1'b1; rx_data[0] = 8'hAA; #1;
    @(negedge clk); abort[0] = 1'b0; rx_valid[0] = 1'b0; #1;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    for (int i = 0; i < 4; i++) put(8'($urandom));
    idle(10);
    chk("abort_out_count", 32'(out_q.size()), 32'd100);
    chk("abort_crc_start_count", 32'(cs_q.size()), 32'd100);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(0, 0, 8'hFE, make_pay(0, 0), 16'h7FA1, 0, 1'b0, F_OK, 8'h00, "post_abort");

    // Reset in the middle of DATA, with a byte offered in the reset cycle.
    sel = 1;
    clear_mon();
    @(negedge clk); arm[1] = 1'b1; #1;
    @(negedge clk); arm[1] = 1'b0; #1;
    put(8'hFE);
    for (int i = 0; i < 4; i++) put(8'(8'h41 + i));
    @(negedge clk); rst = 1'b1; rx_valid[1] = 1'b1; rx_data[1] = 8'h55; #1;
    @(negedge clk); rst = 1'b0; rx_valid[1] = 1'b0; #1;
    chk_zero_outputs(1, "midrst_dut1");
    chk_zero_outputs(0, "midrst_dut0");
    idle(6);
    chk("midrst_out_count", 32'(out_q.size()), 32'd4);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    run_frame(1, 1, 8'hFE, make_pay(1, 1), 16'h31C3, 0, 1'b1, F_OK, 8'h00, "post_rst");

    random_frames(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_block_crc_check.md
Name: spi_block_crc_check

Overview:
Receive-side framing and CRC check for SD-style SPI data blocks. Sits between the SPI byte receiver and the byte-wise CRC16 engine (CCITT 0x1021, init 0x0000). It hunts for the start token, forwards payload bytes downstream, and drives the CRC engine's clr/start/data. It captures the engine's result, compares it with the two trailing CRC bytes and reports ok, CRC error, token error or timeout.

Parameters:
BLOCK_LEN, 512, payload bytes per block (2..4096); byte_cnt width is clog2(BLOCK_LEN).
START_TOKEN, 8'hFE, data start token.
TOKEN_TIMEOUT, 1024, maximum count of 8'hFF bytes accepted while waiting for the token (1..65535).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
arm  in  1  start a block receive; sampled only in IDLE
abort  in  1  return to IDLE immediately; no done pulse
rx_data  in  8  received SPI byte
rx_valid  in  1  one-cycle strobe per byte; back-to-back cycles legal
out_data  out  8  forwarded payload byte (registered)
out_valid  out  1  one-cycle strobe per payload byte
crc_clr  out  1  clear pulse to the CRC engine
crc_start  out  1  byte strobe to the CRC engine
crc_data  out  8  byte to the CRC engine
crc_in  in  16  CRC engine result; valid only while crc_rdy=1
crc_rdy  in  1  CRC engine result strobe (engine latency 1 cycle after crc_start)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
crc_ok  out  1  status: block CRC matched
crc_err  out  1  status: block CRC mismatched
tok_err  out  1  status: a non-FF, non-token byte arrived instead of the token
timeout  out  1  status: the TOKEN_TIMEOUT limit was reached
err_token  out  8  the offending byte when tok_err=1

Behaviour:
- Reset: state=IDLE. All outputs 0, including crc_cap, rx_crc, byte_cnt and ff_cnt.
- States: IDLE, WAIT_TOKEN, DATA, CRC_HI, CRC_LO, CHECK.
- IDLE:
  - arm=1 -> crc_clr=1 for exactly the next cycle.
  - Same cycle: clear crc_ok/crc_err/tok_err/timeout and ff_cnt; go WAIT_TOKEN.
  - Status flags otherwise hold until the next arm.
- WAIT_TOKEN, on rx_valid:
  - rx_data=START_TOKEN -> byte_cnt=0, go DATA.
  - rx_data=8'hFF -> ff_cnt++. If ff_cnt reaches TOKEN_TIMEOUT -> timeout=1, done pulse, go IDLE.
  - Any other byte -> err_token=rx_data, tok_err=1, done pulse, go IDLE.
- DATA, on rx_valid at cycle t:
  - At cycle t+1, crc_start=1, crc_data=rx_data, out_valid=1 and out_data=rx_data.
  - byte_cnt++. When the byte with byte_cnt=BLOCK_LEN-1 is accepted -> go CRC_HI.
  - crc_start is never asserted in the same cycle as crc_clr.
- crc_cap register: loads crc_in whenever crc_rdy=1, in any state.
  - With back-to-back bytes, crc_cap holds the final payload CRC by the CHECK cycle.
- CRC_HI, on rx_valid: rx_crc[15:8]=rx_data, go CRC_LO.
- CRC_LO, on rx_valid: rx_crc[7:0]=rx_data, go CHECK. CRC bytes are not forwarded and not fed to the engine.
- CHECK (exactly one cycle):
  - crc_cap==rx_crc -> crc_ok=1, else crc_err=1.
  - Pulse done and go IDLE. done and the status flag are visible in the same cycle.
- Latency: done is asserted 2 cycles after the rx_valid of the second CRC byte.
- rx_valid in IDLE or CHECK is ignored.
- abort, any state: next state IDLE, and crc_start/out_valid are suppressed from the next cycle.
  - Status flags are left unchanged.
  - abort has priority over arm and rx_valid in the same cycle.
- rst has priority over everything. A mid-block reset leaves no residual strobes.
- Exactly one of crc_ok, crc_err, tok_err and timeout is set after each done.

Test Plan:
1. BLOCK_LEN=512: arm; send 3x FF, FE, 512x FF, then 7F, A1 with rx_valid every cycle -> 512 out_valid pulses carrying FF; done with crc_ok=1, crc_err=0.
2. Same as scenario 1 but with trailing CRC 7F, A0 -> done with crc_err=1, crc_ok=0.
3. BLOCK_LEN=9: send FE, then ASCII "123456789", then 31, C3, with gaps of 0-3 idle cycles between bytes -> crc_ok=1; crc_data sequence is 31..39; crc_clr asserted once, before the first crc_start.
4. TOKEN_TIMEOUT=4: arm, send 4x FF -> timeout=1 and done on the 4th byte's following cycle; arm again, send FF, 05 -> tok_err=1, err_token=8'h05.
5. Abort after 100 payload bytes -> busy=0 the next cycle, no done, no further out_valid. A new arm plus a valid block -> crc_ok=1, confirming crc_clr restarted the CRC.
6. rst asserted mid-DATA -> all outputs 0 on the next cycle, state IDLE; arm pulse while busy has no effect and no extra crc_clr.
